// File: rtl/sd_pkg.sv
// Shared constants, helper functions and sample type for the sigma-delta chain.
package sd_pkg;

   localparam int SD_IN_W = 48;
   localparam int SD_OSR  = 64;

   typedef logic signed [SD_IN_W-1:0] sd_sample_t;

   // Ceiling log2 of a positive value; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Accumulator width of a CIC: input width plus bit growth of OSR^ORDER.
   function automatic int acc_w(input int in_w, input int osr, input int order);
      return in_w + order * clog2(osr);
   endfunction

endpackage

// File: rtl/sd_cic_comb.sv
// Single CIC comb stage (differential delay 1). y = x - x_prev, where x_prev is
// the value x had at the previous enabled edge. Arithmetic wraps modulo 2^ACC_W.
module sd_cic_comb #(
   parameter int ACC_W = 66
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [ACC_W-1:0] x,
   output logic [ACC_W-1:0] y
);

   logic [ACC_W-1:0] dly;

   assign y = x - dly;

   // Delay register captures the comb input once per decimated sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dly <= '0;
      end else if (clr) begin
         dly <= '0;
      end else if (en) begin
         dly <= x;
      end
   end

endmodule

// File: rtl/sd_cic_decimator.sv
// Decimating CIC (ORDER integrators at input rate, ORDER combs at output rate)
// behind the sigma-delta digital filter. Output gain is normalised by taking the
// top OUT_W bits of the ACC_W-bit comb result.
// Optional feature: define SD_CIC_ROUND_EN for round-half-up with positive
// saturation instead of plain truncation toward -inf.
//
// Output handshake: out_valid means out_data holds a sample not yet consumed;
// a transfer happens on an edge where out_valid and out_ready are both high.
// A new sample arriving while out_valid is high and out_ready is low is
// dropped (out_data keeps the old sample) and sets the sticky overrun flag.
module sd_cic_decimator
   import sd_pkg::*;
#(
   parameter int IN_W  = SD_IN_W,
   parameter int OUT_W = 24,
   parameter int OSR   = SD_OSR,
   parameter int ORDER = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   input  logic             clr,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             settled,
   output logic             overrun
);

   localparam int ACC_W = acc_w(IN_W, OSR, ORDER);
   localparam int PH_W  = (clog2(OSR) < 1) ? 1 : clog2(OSR);
   localparam int CNT_W = 3;

   logic [ACC_W-1:0] in_ext;
   logic [ACC_W-1:0] integ  [ORDER];
   logic [ACC_W-1:0] comb_x [ORDER+1];
   logic [PH_W-1:0]  phase;
   logic             dec_stb;
   logic [CNT_W-1:0] out_cnt;
   logic [OUT_W-1:0] norm;

   assign in_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

   // Integrator chain and decimation phase; dec_stb marks the edge after the OSR-th input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < ORDER; k++) integ[k] <= '0;
         phase   <= '0;
         dec_stb <= 1'b0;
      end else if (clr) begin
         for (int k = 0; k < ORDER; k++) integ[k] <= '0;
         phase   <= '0;
         dec_stb <= 1'b0;
      end else begin
         dec_stb <= 1'b0;
         if (in_valid) begin
            integ[0] <= integ[0] + in_ext;
            for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
            phase <= phase + 1'b1;
            if (phase == PH_W'(OSR - 1)) dec_stb <= 1'b1;
         end
      end
   end

   assign comb_x[0] = integ[ORDER-1];

   for (genvar k = 0; k < ORDER; k++) begin : g_comb
      sd_cic_comb #(.ACC_W(ACC_W)) u_comb (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (clr),
         .en      (dec_stb),
         .x       (comb_x[k]),
         .y       (comb_x[k+1])
      );
   end

`ifdef SD_CIC_ROUND_EN
   localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (ACC_W - OUT_W - 1);
   logic [ACC_W:0] rnd;

   // Round half-up; a positive result pushed past full scale clamps to max.
   always_comb begin
      rnd = {comb_x[ORDER][ACC_W-1], comb_x[ORDER]} + HALF;
      if (!rnd[ACC_W] && rnd[ACC_W-1]) norm = {1'b0, {(OUT_W-1){1'b1}}};
      else                             norm = rnd[ACC_W-1 -: OUT_W];
   end
`else
   assign norm = comb_x[ORDER][ACC_W-1 -: OUT_W];
`endif

   // Output register, handshake, overrun flag and settle counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         out_cnt   <= '0;
      end else if (clr) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         out_cnt   <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (dec_stb) begin
            if (out_cnt != CNT_W'(ORDER)) out_cnt <= out_cnt + 1'b1;
            if (out_valid && !out_ready) begin
               overrun <= 1'b1;
            end else begin
               out_data  <= norm;
               out_valid <= 1'b1;
            end
         end
      end
   end

   assign settled = (out_cnt == CNT_W'(ORDER));

endmodule
